// File: rtl/cube_root_seq.sv
// Sequential integer cube root: returns floor(cbrt(y)), the remainder y - root^3
// and an exact flag, resolving one root bit per clock, MSB first.
module cube_root_seq #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  y_in,
    output logic [OUT_W-1:0] root_out,
    output logic [IN_W-1:0]  rem_out,
    output logic             exact,
    output logic             busy,
    output logic             finish
);

    localparam int CUBE_W = 3 * OUT_W;
    localparam int IDX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IN_W-1:0]  y_r, y_next;
    logic [OUT_W-1:0] root_r, root_next;
    logic [IDX_W-1:0] bit_idx, idx_next;
    logic [OUT_W-1:0] root_out_next;
    logic [IN_W-1:0]  rem_next;
    logic             exact_next;

    // Operand is widened before multiplying so the product never wraps.
    function automatic logic [CUBE_W-1:0] cube(input logic [OUT_W-1:0] v);
        logic [CUBE_W-1:0] w;
        w = CUBE_W'(v);
        return w * w * w;
    endfunction

    logic [OUT_W-1:0]  trial;
    logic              trial_fits;
    logic [OUT_W-1:0]  root_calc;
    logic [CUBE_W-1:0] final_cube;

    assign trial      = root_r | (OUT_W'(1) << bit_idx);
    assign trial_fits = (cube(trial) <= CUBE_W'(y_r));
    assign root_calc  = trial_fits ? trial : root_r;
    assign final_cube = cube(root_calc);

    assign busy   = (state == CALC);
    assign finish = (state == DONE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_next    = state;
        y_next        = y_r;
        root_next     = root_r;
        idx_next      = bit_idx;
        root_out_next = root_out;
        rem_next      = rem_out;
        exact_next    = exact;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    y_next     = y_in;
                    root_next  = '0;
                    idx_next   = TOP_IDX;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                root_next = root_calc;
                if (bit_idx == '0) begin
                    // Results are loaded on the edge entering DONE and held until the next DONE.
                    state_next    = DONE;
                    root_out_next = root_calc;
                    rem_next      = y_r - IN_W'(final_cube);
                    exact_next    = (y_r == IN_W'(final_cube));
                end else begin
                    idx_next = bit_idx - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state    <= IDLE;
            y_r      <= '0;
            root_r   <= '0;
            bit_idx  <= '0;
            root_out <= '0;
            rem_out  <= '0;
            exact    <= 1'b0;
        end else begin
            state    <= state_next;
            y_r      <= y_next;
            root_r   <= root_next;
            bit_idx  <= idx_next;
            root_out <= root_out_next;
            rem_out  <= rem_next;
            exact    <= exact_next;
        end
    end

endmodule

// File: tb/tb_cube_root_seq.sv
// Self-checking bench for cube_root_seq: directed table, handshake corner cases,
// full sweep and random operands against an arithmetic cube-root model.
module tb_cube_root_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] y_in;
    logic [1:0] root_out;
    logic [5:0] rem_out;
    logic       exact;
    logic       busy;
    logic       finish;

    int checks = 0;
    int errors = 0;

    cube_root_seq #(.IN_W(6), .OUT_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .y_in(y_in),
        .root_out(root_out), .rem_out(rem_out), .exact(exact),
        .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] y;
        int         root;
        int         rem;
        int         ex;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Largest r with r^3 <= y, found by counting up.
    function automatic int cbrt_ref(input int y);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= y) r++;
        return r;
    endfunction

    // Issue one operation from IDLE, wait for finish, check latency, results and pulse width.
    task automatic do_op(input logic [5:0] y, input int exp_root, input int exp_rem,
                         input int exp_ex, input string name);
        int lat;
        bit got;
        start = 1'b1;
        y_in  = y;
        @(negedge clk);
        start = 1'b0;
        y_in  = 6'($urandom);
        lat   = 1;
        got   = 1'b0;
        while (!got && lat <= 10) begin
            if (finish) got = 1'b1;
            else begin
                check({name, " busy_in_calc"}, int'(busy), (lat < 3) ? 1 : 0);
                @(negedge clk);
                lat++;
            end
        end
        check({name, " latency"}, lat, 3);
        check({name, " root"}, int'(root_out), exp_root);
        check({name, " rem"}, int'(rem_out), exp_rem);
        check({name, " exact"}, int'(exact), exp_ex);
        check({name, " busy_with_finish"}, int'(busy), 0);
        @(negedge clk);
        check({name, " finish_pulse"}, int'(finish), 0);
        check({name, " root_held"}, int'(root_out), exp_root);
    endtask

    vec_t vecs[7];

    initial begin
        int r, bcnt, ry;

        vecs[0] = '{y: 6'd8,  root: 2, rem: 0,  ex: 1};
        vecs[1] = '{y: 6'd27, root: 3, rem: 0,  ex: 1};
        vecs[2] = '{y: 6'd63, root: 3, rem: 36, ex: 0};
        vecs[3] = '{y: 6'd0,  root: 0, rem: 0,  ex: 1};
        vecs[4] = '{y: 6'd1,  root: 1, rem: 0,  ex: 1};
        vecs[5] = '{y: 6'd7,  root: 1, rem: 6,  ex: 0};
        vecs[6] = '{y: 6'd26, root: 2, rem: 18, ex: 0};

        rst   = 1'b1;
        start = 1'b0;
        y_in  = '0;
        repeat (2) @(negedge clk);
        check("reset root", int'(root_out), 0);
        check("reset rem", int'(rem_out), 0);
        check("reset exact", int'(exact), 0);
        check("reset busy", int'(busy), 0);
        check("reset finish", int'(finish), 0);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) do_op(vecs[i].y, vecs[i].root, vecs[i].rem, vecs[i].ex, $sformatf("vec%0d", i));

        // Start held high: second operand captured in the DONE cycle only
        start = 1'b1;
        y_in  = 6'd8;
        @(negedge clk);
        y_in = 6'd63;
        @(negedge clk);
        @(negedge clk);
        check("b2b first finish", int'(finish), 1);
        check("b2b first root", int'(root_out), 2);
        y_in = 6'd27;
        @(negedge clk);
        y_in = 6'd63;
        check("b2b gap1 finish", int'(finish), 0);
        check("b2b gap1 busy", int'(busy), 1);
        @(negedge clk);
        check("b2b gap2 finish", int'(finish), 0);
        check("b2b held root", int'(root_out), 2);
        @(negedge clk);
        start = 1'b0;
        check("b2b second finish", int'(finish), 1);
        check("b2b second root", int'(root_out), 3);
        @(negedge clk);
        check("b2b idle", int'(finish | busy), 0);

        // Start during CALC is ignored
        start = 1'b1;
        y_in  = 6'd8;
        @(negedge clk);
        y_in = 6'd63;
        bcnt = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) start = 1'b0;
            if (busy) bcnt++;
            if (busy && finish) check("calc busy&finish", 1, 0);
            if (c == 3) begin
                check("calc ignore finish", int'(finish), 1);
                check("calc ignore root", int'(root_out), 2);
            end
            @(negedge clk);
        end
        check("calc busy cycles", bcnt, 2);

        // Reset mid-CALC aborts without a finish pulse
        start = 1'b1;
        y_in  = 6'd27;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort root", int'(root_out), 0);
        check("abort rem", int'(rem_out), 0);
        check("abort busy", int'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            check("abort no finish", int'(finish), 0);
            @(negedge clk);
        end
        // Reset wins over start on the same edge
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst over start busy", int'(busy), 0);
        @(negedge clk);
        check("rst over start finish", int'(finish), 0);
        do_op(6'd27, 3, 0, 1, "after abort");

        // Full sweep against the model
        for (int y = 0; y < 64; y++) begin
            r = cbrt_ref(y);
            do_op(6'(y), r, y - r * r * r, (y == r * r * r) ? 1 : 0, $sformatf("sweep y=%0d", y));
        end

        // Random operands
        for (int k = 0; k < 16; k++) begin
            ry = int'($urandom_range(0, 63));
            r  = cbrt_ref(ry);
            do_op(6'(ry), r, ry - r * r * r, (ry == r * r * r) ? 1 : 0, $sformatf("rand y=%0d", ry));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
